// File: rtl/instr_fetch_unit_if.sv
// Instruction fetch bus bundle.
// Groups the instruction-memory handshake (imem_req/imem_addr/imem_ack/imem_rdata)
// and the decoder-side instruction handshake (instr/opcode/pc_out/instr_valid/
// instr_ready plus the branch/jump/zero next-PC controls and fetch_err).
//   master : the fetch unit (drives req/addr and the presented instruction)
//   slave  : memory + decoder/datapath side
interface instr_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [31:0] pc_out;
   logic        instr_valid;
   logic        instr_ready;
   logic        branch;
   logic        jump;
   logic        zero;
   logic        fetch_err;

   modport master (
      output imem_req, imem_addr, instr, opcode, pc_out, instr_valid, fetch_err,
      input  imem_ack, imem_rdata, instr_ready, branch, jump, zero
   );

   modport slave (
      input  imem_req, imem_addr, instr, opcode, pc_out, instr_valid, fetch_err,
      output imem_ack, imem_rdata, instr_ready, branch, jump, zero
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit.
// Fetches one 32-bit word at a time over a req/ack memory handshake, presents it
// (instr, opcode, pc_out, instr_valid) to the decoder, and on acceptance picks the
// next PC from jump / branch&zero / sequential. One instruction in flight.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : instr_fetch_unit_if.master (memory handshake, instruction handshake,
//            next-PC controls, sticky fetch_err)
// All outputs are registered; opcode is a slice of the registered instr.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   instr_fetch_unit_if.master bus
);

   // wait counter only has to reach TIMEOUT-1
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_VALID, S_ERR} state_t;

   state_t          state, state_nx;
   logic [31:0]     pc, pc_nx;          // current fetch address (drives imem_addr)
   logic [31:0]     pc_out_r, pc_out_nx;
   logic [31:0]     instr_r, instr_nx;
   logic            req_r, req_nx;
   logic            valid_r, valid_nx;
   logic            err_r, err_nx;
   logic [CW-1:0]   cnt, cnt_nx;

   logic [31:0]     pc4, br_off, npc;

   // next-PC selection, only consumed on the accept cycle
   always_comb begin
      pc4    = pc_out_r + 32'd4;
      br_off = {{14{instr_r[15]}}, instr_r[15:0], 2'b00};
      if (bus.jump)
         npc = {pc4[31:28], instr_r[25:0], 2'b00};
      else if (bus.branch && bus.zero)
         npc = pc4 + br_off;
      else
         npc = pc4;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         pc       <= RESET_PC;
         pc_out_r <= RESET_PC;
         instr_r  <= 32'd0;
         req_r    <= 1'b0;
         valid_r  <= 1'b0;
         err_r    <= 1'b0;
         cnt      <= '0;
      end else begin
         state    <= state_nx;
         pc       <= pc_nx;
         pc_out_r <= pc_out_nx;
         instr_r  <= instr_nx;
         req_r    <= req_nx;
         valid_r  <= valid_nx;
         err_r    <= err_nx;
         cnt      <= cnt_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      pc_nx     = pc;
      pc_out_nx = pc_out_r;
      instr_nx  = instr_r;
      req_nx    = req_r;
      valid_nx  = valid_r;
      err_nx    = err_r;
      cnt_nx    = cnt;
      case (state)
         S_IDLE: begin
            // a misaligned RESET_PC is the only way an unaligned fetch could start
            if (pc[1:0] != 2'b00) begin
               err_nx   = 1'b1;
               state_nx = S_ERR;
            end else begin
               req_nx   = 1'b1;
               cnt_nx   = '0;
               state_nx = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.imem_ack) begin
               instr_nx  = bus.imem_rdata;
               pc_out_nx = pc;
               valid_nx  = 1'b1;
               req_nx    = 1'b0;
               state_nx  = S_VALID;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               // this is the TIMEOUT-th cycle without an ack
               req_nx   = 1'b0;
               err_nx   = 1'b1;
               state_nx = S_ERR;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         S_VALID: begin
            if (valid_r && bus.instr_ready) begin
               valid_nx = 1'b0;
               if (npc[1:0] != 2'b00) begin
                  err_nx   = 1'b1;
                  state_nx = S_ERR;
               end else begin
                  // back-to-back: request goes out the same cycle valid drops
                  pc_nx    = npc;
                  req_nx   = 1'b1;
                  cnt_nx   = '0;
                  state_nx = S_WAIT;
               end
            end
         end
         S_ERR: begin
            req_nx   = 1'b0;
            valid_nx = 1'b0;
         end
         default: state_nx = S_ERR;
      endcase
   end

   assign bus.imem_req    = req_r;
   assign bus.imem_addr   = pc;
   assign bus.instr       = instr_r;
   assign bus.opcode      = instr_r[31:26];
   assign bus.pc_out      = pc_out_r;
   assign bus.instr_valid = valid_r;
   assign bus.fetch_err   = err_r;

endmodule
